fifo_wr_ptr_full: RTL
=====================

Name: fifo_wr_ptr_full

Overview:
Write-side control stage for the dual-clock FIFO, running entirely in the wr_clk domain and sitting directly upstream of the FIFO memory.
- Accepts write requests from the producer.
- Gates them into the memory write enable.
- Generates the binary write address and the Gray-coded write pointer that is exported to the read domain.
- Synchronises the read domain's Gray pointer and derives full, almost_full, fill level and a sticky overflow flag.

Parameters:
S, 12, width of the write address driven to the FIFO memory; must be > ADDR_W.
ADDR_W, 7, log2 of usable FIFO depth; DEPTH = 2^ADDR_W = 128 entries, which fits within the 150-entry memory.
AF_MARGIN, 4, almost_full asserts when level >= DEPTH - AF_MARGIN.

Ports:
wr_clk  input  1  write-domain clock; all state updates on rising edge.
wr_rst_n  input  1  asynchronous, active-low reset.
wr_req  input  1  producer push request, sampled on wr_clk.
rd_gray_ptr  input  ADDR_W+1  read pointer, Gray-coded, from the rd_clk domain; asynchronous to wr_clk.
wr_en  output  1  write enable to the FIFO memory.
wr_ptr  output  S  write address to the FIFO memory: binary pointer bits [ADDR_W-1:0], zero-extended.
wr_gray_ptr  output  ADDR_W+1  registered Gray write pointer, exported to the read domain.
full  output  1  FIFO full, registered.
almost_full  output  1  level >= DEPTH - AF_MARGIN, registered.
wr_level  output  ADDR_W+1  conservative occupancy, 0..DEPTH, registered.
overflow  output  1  sticky flag: push attempted while full.

Behaviour:
- Reset (wr_rst_n low, takes effect immediately, no clock needed):
  - Clears the binary pointer wbin[ADDR_W:0], wr_gray_ptr, both synchroniser flops, full, almost_full, wr_level and overflow.
  - wr_en = 0 while in reset. wr_ptr = 0.
- Push acceptance: wr_en = wr_req & ~full & wr_rst_n (combinational).
  - The memory captures data at wr_ptr on the same wr_clk edge.
  - wbin increments by 1 on that edge (mod 2^(ADDR_W+1)).
- Pointer encoding:
  - wbin_next = wbin + wr_en.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - wr_gray_ptr <= wgray_next, i.e. output straight from a flop with no combinational glitch path into the CDC.
- Synchroniser: rq1 <= rd_gray_ptr; rq2 <= rq1. Only rq2 is used downstream.
- Full flag: full <= (wgray_next == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}).
  - full asserts on the same edge as the push that fills the last entry.
  - A read is reflected in full no earlier than the 3rd wr_clk edge after rd_gray_ptr changes (2 sync flops + registered compare). This pessimism is required and acceptable.
- Level:
  - rbin_s = Gray-to-binary(rq2).
  - wr_level <= (wbin_next - rbin_s) mod 2^(ADDR_W+1). Always within 0..DEPTH.
  - almost_full <= (wbin_next - rbin_s) >= DEPTH - AF_MARGIN.
- Overflow: set on any edge where wr_req & full; held until reset. The rejected push changes no pointer state.
- Wrap-around:
  - wbin rolls from 2^(ADDR_W+1)-1 to 0.
  - The MSB of wbin/Gray distinguishes full from empty.
  - wr_ptr wraps from DEPTH-1 to 0.
- Simultaneous push and read-pointer change: the push is decided on the current full value. The read is seen via rq2 later.
- Reset mid-burst: any in-flight push is dropped and the pointer returns to 0. The read side must be reset together with this block.
- rd_gray_ptr must change by at most one bit per rd_clk edge (the read side guarantees this).

Test Plan:
1. Assert wr_rst_n=0 asynchronously mid-cycle -> wr_ptr, wr_gray_ptr, wr_level, full, almost_full and overflow all read 0 immediately; wr_en=0 even with wr_req=1.
2. rd_gray_ptr=0, 128 consecutive wr_req -> wr_ptr steps 0..127 then back to 0.
   - After the 124th push, almost_full=1 and wr_level=124.
   - After the 128th push, full=1, wr_level=128, wr_gray_ptr=8'hC0.
3. While full, hold wr_req=1 for 3 cycles -> wr_en=0, pointers unchanged, overflow=1, and overflow stays 1 after wr_req drops.
4. From the full state, change rd_gray_ptr to 8'h01 -> full=1 through the 2nd wr_clk edge, full=0 after the 3rd edge, wr_level=127; the next wr_req produces wr_en=1 at wr_ptr=0.
5. Reader tracks the writer (rd_gray_ptr = wr_gray_ptr delayed 4 cycles), 300 pushes -> full never asserts, overflow=0, wbin wraps past 255, and wr_gray_ptr changes exactly one bit per push.
6. Reset asserted after 50 pushes, released, then 1 push -> wr_ptr=1, wr_gray_ptr=8'h01, overflow=0.

Source files
------------

// File: rtl/fifo_wr_ptr_full.sv
// rtl/fifo_wr_ptr_full.sv - write-side pointer, Gray export and full/level logic of the dual-clock FIFO
module fifo_wr_ptr_full #(
    parameter int S         = 12,
    parameter int ADDR_W    = 7,
    parameter int AF_MARGIN = 4
) (
    input  logic              wr_clk,
    input  logic              wr_rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W:0]   rd_gray_ptr,
    output logic              wr_en,
    output logic [S-1:0]      wr_ptr,
    output logic [ADDR_W:0]   wr_gray_ptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

    logic [ADDR_W:0] wbin_q, wbin_d;
    logic [ADDR_W:0] wgray_q, wgray_d;
    logic [ADDR_W:0] rq1_q, rq1_d;
    logic [ADDR_W:0] rq2_q, rq2_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            full_q, full_d;
    logic            almost_full_q, almost_full_d;
    logic            overflow_q, overflow_d;
    logic [ADDR_W:0] rbin_s;

    always_comb begin
        wr_en   = wr_req & ~full_q & wr_rst_n;
        wbin_d  = wbin_q + {{ADDR_W{1'b0}}, wr_en};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        rq1_d   = rd_gray_ptr;
        rq2_d   = rq1_q;

        // Each binary bit is the XOR of all Gray bits at or above it.
        rbin_s = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin_s[i] = ^(rq2_q >> i);
        end

        level_d       = wbin_d - rbin_s;
        full_d        = (wgray_d == {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]});
        almost_full_d = (level_d >= AF_THRESH);
        overflow_d    = overflow_q | (wr_req & full_q);
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wbin_q        <= '0;
            wgray_q       <= '0;
            rq1_q         <= '0;
            rq2_q         <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            wgray_q       <= wgray_d;
            rq1_q         <= rq1_d;
            rq2_q         <= rq2_d;
            level_q       <= level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wr_ptr      = {{(S - ADDR_W){1'b0}}, wbin_q[ADDR_W-1:0]};
    assign wr_gray_ptr = wgray_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign wr_level    = level_q;
    assign overflow    = overflow_q;

endmodule
